// File: rtl/calc_entry_ctrl.sv
// Keypad entry controller: builds a signed 3-digit BCD display buffer from key
// events and hands the converted 11-bit operand downstream over valid/ready.

module bcdtobin (
    input  logic [31:0] bcd_i,
    output logic [10:0] bin_o
);

    logic [10:0] acc;
    logic        neg;
    logic [3:0]  nib;

    // Scan MSB to LSB: digits accumulate, 0xE marks minus, other codes are blanks.
    always_comb begin
        acc = 11'd0;
        neg = 1'b0;
        nib = 4'h0;
        for (int i = 7; i >= 0; i--) begin
            nib = bcd_i[i*4 +: 4];
            if (nib <= 4'd9) begin
                acc = acc * 11'd10 + {7'd0, nib};
            end else if (nib == 4'hE) begin
                neg = 1'b1;
            end
        end
        bin_o = neg ? -acc : acc;
    end

endmodule

module calc_entry_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        op_ready,
    output logic [31:0] disp,
    output logic [10:0] op_data,
    output logic        op_valid,
    output logic        key_err
);

    typedef enum logic [1:0] {
        ST_ENTRY,
        ST_CONV,
        ST_PRESENT
    } state_e;

    localparam logic [3:0] KEY_NEG   = 4'hA;
    localparam logic [3:0] KEY_BKSP  = 4'hB;
    localparam logic [3:0] KEY_CLR   = 4'hC;
    localparam logic [3:0] KEY_ENTER = 4'hD;
    localparam logic [3:0] BLANK     = 4'hF;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        neg_q, neg_d;
    logic [3:0]  d2_q, d2_d;
    logic [3:0]  d1_q, d1_d;
    logic [3:0]  d0_q, d0_d;
    logic [10:0] op_data_q, op_data_d;
    logic        op_valid_q, op_valid_d;
    logic        key_err_q, key_err_d;
    logic [10:0] conv_bin;

    // Unused digit positions hold 0xF so the buffer is pure register wiring.
    assign disp = {16'hFFFF, (neg_q ? 4'hE : BLANK), d2_q, d1_q, d0_q};

    bcdtobin u_bcdtobin (
        .bcd_i (disp),
        .bin_o (conv_bin)
    );

    assign op_data  = op_data_q;
    assign op_valid = op_valid_q;
    assign key_err  = key_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_ENTRY;
            cnt_q      <= 2'd0;
            neg_q      <= 1'b0;
            d2_q       <= BLANK;
            d1_q       <= BLANK;
            d0_q       <= BLANK;
            op_data_q  <= 11'd0;
            op_valid_q <= 1'b0;
            key_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            neg_q      <= neg_d;
            d2_q       <= d2_d;
            d1_q       <= d1_d;
            d0_q       <= d0_d;
            op_data_q  <= op_data_d;
            op_valid_q <= op_valid_d;
            key_err_q  <= key_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        neg_d      = neg_q;
        d2_d       = d2_q;
        d1_d       = d1_q;
        d0_d       = d0_q;
        op_data_d  = op_data_q;
        op_valid_d = op_valid_q;
        key_err_d  = 1'b0;

        unique case (state_q)
            ST_ENTRY: begin
                if (key_valid) begin
                    if (key_code <= 4'd9) begin
                        if (cnt_q == 2'd3) begin
                            key_err_d = 1'b1;
                        end else if (cnt_q == 2'd1 && d0_q == 4'd0) begin
                            // A lone leading zero is overwritten, not shifted.
                            d0_d = key_code;
                        end else begin
                            d2_d  = d1_q;
                            d1_d  = d0_q;
                            d0_d  = key_code;
                            cnt_d = cnt_q + 2'd1;
                        end
                    end else begin
                        unique case (key_code)
                            KEY_NEG: begin
                                neg_d = ~neg_q;
                            end
                            KEY_BKSP: begin
                                if (cnt_q != 2'd0) begin
                                    d0_d  = d1_q;
                                    d1_d  = d2_q;
                                    d2_d  = BLANK;
                                    cnt_d = cnt_q - 2'd1;
                                end else begin
                                    neg_d = 1'b0;
                                end
                            end
                            KEY_CLR: begin
                                cnt_d = 2'd0;
                                neg_d = 1'b0;
                                d2_d  = BLANK;
                                d1_d  = BLANK;
                                d0_d  = BLANK;
                            end
                            KEY_ENTER: begin
                                state_d = ST_CONV;
                            end
                            default: begin
                                key_err_d = 1'b1;
                            end
                        endcase
                    end
                end
            end

            ST_CONV: begin
                key_err_d  = key_valid;
                op_data_d  = conv_bin;
                op_valid_d = 1'b1;
                state_d    = ST_PRESENT;
            end

            ST_PRESENT: begin
                key_err_d = key_valid;
                if (op_ready) begin
                    op_valid_d = 1'b0;
                    cnt_d      = 2'd0;
                    neg_d      = 1'b0;
                    d2_d       = BLANK;
                    d1_d       = BLANK;
                    d0_d       = BLANK;
                    state_d    = ST_ENTRY;
                end
            end

            default: begin
                state_d = ST_ENTRY;
            end
        endcase
    end

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Bench for calc_entry_ctrl: directed key sequences, operand scoreboard
// checked by an independent handshake monitor.

module tb_calc_entry_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        op_ready;
    logic [31:0] disp;
    logic [10:0] op_data;
    logic        op_valid;
    logic        key_err;

    int n_cmp = 0;
    int n_bad = 0;
    logic [10:0] exp_q[$];

    calc_entry_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .key_valid (key_valid),
        .key_code  (key_code),
        .op_ready  (op_ready),
        .disp      (disp),
        .op_data   (op_data),
        .op_valid  (op_valid),
        .key_err   (key_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] code, input logic exp_err);
        key_valid = 1'b1;
        key_code  = code;
        tick();
        key_valid = 1'b0;
        check("key_err", {31'd0, key_err}, {31'd0, exp_err});
    endtask

    // ENTER with op_ready high: one-cycle CONV, then a handshake cycle.
    task automatic enter_and_take(input logic [10:0] exp);
        exp_q.push_back(exp);
        press(4'hD, 1'b0);
        check("valid_in_conv", {31'd0, op_valid}, 32'd0);
        tick();
        check("valid_present", {31'd0, op_valid}, 32'd1);
        tick();
        check("valid_after_hs", {31'd0, op_valid}, 32'd0);
        check("disp_after_hs", disp, 32'hFFFF_FFFF);
    endtask

    // Monitor: every handshake must match the next expected operand.
    always @(negedge clk) begin
        if (!reset && op_valid && op_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL op_data: unexpected operand %h", op_data);
            end else begin
                logic [10:0] e;
                e = exp_q.pop_front();
                if (op_data !== e) begin
                    n_bad++;
                    $display("FAIL op_data: got %h expected %h", op_data, e);
                end
            end
        end
    end

    initial begin
        reset     = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'h0;
        op_ready  = 1'b0;
        tick();
        tick();
        check("rst_disp", disp, 32'hFFFF_FFFF);
        check("rst_valid", {31'd0, op_valid}, 32'd0);
        check("rst_data", {21'd0, op_data}, 32'd0);
        check("rst_err", {31'd0, key_err}, 32'd0);
        reset = 1'b0;
        tick();

        // Basic entry
        op_ready = 1'b1;
        press(4'h1, 1'b0);
        press(4'h2, 1'b0);
        press(4'h3, 1'b0);
        check("disp_123", disp, 32'hFFFF_F123);
        enter_and_take(11'h07B);

        // Negative max, then lone minus
        press(4'h9, 1'b0);
        press(4'h9, 1'b0);
        press(4'h9, 1'b0);
        press(4'hA, 1'b0);
        check("disp_n999", disp, 32'hFFFF_E999);
        enter_and_take(11'h419);
        press(4'hA, 1'b0);
        check("disp_neg", disp, 32'hFFFF_EFFF);
        enter_and_take(11'h000);

        // Limits and editing
        press(4'h1, 1'b0);
        press(4'h2, 1'b0);
        press(4'h3, 1'b0);
        press(4'h4, 1'b1);
        check("disp_full", disp, 32'hFFFF_F123);
        tick();
        check("err_one_cycle", {31'd0, key_err}, 32'd0);
        press(4'hC, 1'b0);
        check("disp_clr", disp, 32'hFFFF_FFFF);
        press(4'h0, 1'b0);
        press(4'h0, 1'b0);
        check("disp_00", disp, 32'hFFFF_FFF0);
        press(4'h5, 1'b0);
        check("disp_005", disp, 32'hFFFF_FFF5);
        press(4'hC, 1'b0);
        press(4'h4, 1'b0);
        press(4'h5, 1'b0);
        check("disp_45", disp, 32'hFFFF_FF45);
        press(4'hB, 1'b0);
        check("disp_bksp", disp, 32'hFFFF_FFF4);
        press(4'hC, 1'b0);
        press(4'hA, 1'b0);
        press(4'hB, 1'b0);
        check("disp_bksp_neg", disp, 32'hFFFF_FFFF);
        press(4'hB, 1'b0);
        check("disp_bksp_empty", disp, 32'hFFFF_FFFF);
        press(4'h6, 1'b0);
        press(4'hE, 1'b1);
        press(4'hF, 1'b1);
        check("disp_badcode", disp, 32'hFFFF_FFF6);
        press(4'hC, 1'b0);

        // Backpressure
        op_ready = 1'b0;
        press(4'h4, 1'b0);
        press(4'h2, 1'b0);
        exp_q.push_back(11'd42);
        press(4'hD, 1'b0);
        tick();
        for (int i = 0; i < 6; i++) begin
            press(4'(i + 1), 1'b1);
            check("bp_valid", {31'd0, op_valid}, 32'd1);
            check("bp_data", {21'd0, op_data}, 32'd42);
            check("bp_disp", disp, 32'hFFFF_FF42);
        end
        op_ready = 1'b1;
        press(4'h7, 1'b1);
        check("hs_valid", {31'd0, op_valid}, 32'd0);
        check("hs_disp", disp, 32'hFFFF_FFFF);
        tick();
        check("hs_single", {31'd0, op_valid}, 32'd0);

        // Reset during PRESENT discards the operand
        op_ready = 1'b0;
        press(4'h8, 1'b0);
        press(4'hD, 1'b0);
        tick();
        check("pre_rst_valid", {31'd0, op_valid}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_valid", {31'd0, op_valid}, 32'd0);
        check("mid_rst_disp", disp, 32'hFFFF_FFFF);
        check("mid_rst_data", {21'd0, op_data}, 32'd0);
        op_ready = 1'b1;
        press(4'h7, 1'b0);
        enter_and_take(11'd7);

        tick();
        check("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/calc_entry_ctrl.md
# calc_entry_ctrl

Keypad-entry controller for the calculator operand path. It turns single-cycle key events into the 32-bit BCD display buffer and sequences conversion of that buffer into a signed 11-bit operand through an internal `bcdtobin` instance. It then presents the operand to the downstream ALU/sequencer with a valid/ready handshake. It sits between the key decoder and the arithmetic stage, and also drives the display.

## Interface
Parameters: none. Digit capacity is fixed at 3, giving a range of −999..999.

- `clk` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `key_valid` in 1: one-cycle key event strobe.
- `key_code` in 4: 0x0–0x9 digit, 0xA NEG, 0xB BKSP, 0xC CLR, 0xD ENTER, 0xE/0xF undefined.
- `op_ready` in 1: downstream accepts operand.
- `disp` out 32: BCD display buffer; nibble 0 = ones, 0xE = minus, 0xF = blank.
- `op_data` out 11: signed operand, two's complement.
- `op_valid` out 1: operand valid.
- `key_err` out 1: one-cycle pulse, key rejected.

## Operation
- Internal state: `cnt` (0..3 digits entered), `neg` flag, digit nibbles d2..d0, FSM {ENTRY, CONV, PRESENT}.
- disp composition:
  - [31:16] = 0xFFFF always.
  - [15:12] = 0xE if `neg`, else 0xF.
  - [11:0] = d2 d1 d0, with unused positions = 0xF.
  - Empty buffer shows FFFFFFFF.
- ENTRY, key_valid=1:
  - **Digit, cnt<3:** shift d1→d2, d0→d1, new→d0; cnt++.
    - Exception: if cnt==1 and d0==0, replace d0 and leave cnt unchanged (no leading zeros).
  - **Digit, cnt==3:** ignored; key_err.
  - **NEG:** toggle `neg`. Allowed with cnt==0.
  - **BKSP:**
    - cnt>0: shift d2→d1, d1→d0, d2←0xF; cnt--.
    - cnt==0: clear `neg`.
  - **CLR:** cnt=0, neg=0, digits blank.
  - **ENTER:** go to CONV.
  - **0xE/0xF:** ignored; key_err.
- CONV (exactly 1 cycle):
  - op_data ← bcdtobin(disp[31:0]).
  - Go to PRESENT; op_valid=1.
- PRESENT:
  - op_valid and op_data are held stable until op_valid&op_ready.
  - On handshake: clear the buffer (as CLR), op_valid←0, go to ENTRY.
  - op_data keeps its last value until the next CONV.
- Any key_valid in CONV or PRESENT is ignored and pulses key_err. This includes a key in the handshake cycle.
- Arithmetic: the 3-digit limit guarantees |value| ≤ 999, so 11-bit signed never overflows. "−" with no digits converts to 0.
- Reset (any state, including mid-PRESENT):
  - FSM=ENTRY, cnt=0, neg=0.
  - disp=32'hFFFF_FFFF, op_data=0, op_valid=0, key_err=0.
  - Any pending operand is discarded.

## Timing
- All outputs are registered. Key accepted at edge t → disp updates after edge t (visible in cycle t+1).
- key_err is asserted in the cycle after the rejected key, for one cycle only.
- ENTER sampled at edge t → CONV during t+1 → op_valid=1 and op_data valid from cycle t+2. Latency is 2 cycles.
- Handshake completes at the edge where op_valid&op_ready=1. In the next cycle op_valid=0 and disp=FFFFFFFF, and new keys are accepted.
- Minimum ENTER-to-next-accepted-key is 3 cycles when op_ready is held high.
- op_ready is ignored outside PRESENT.
- reset has priority over all events in the same cycle.

## Test plan
- **Reset:** assert reset 2 cycles → disp=FFFFFFFF, op_valid=0, op_data=0, key_err=0.
- **Basic entry:** keys 1,2,3, ENTER, op_ready=1 → disp=FFFFF123; op_valid rises 2 cycles after ENTER with op_data=123 (11'h07B); the following cycle disp=FFFFFFFF and op_valid=0.
- **Negative max:** keys 9,9,9, NEG, ENTER → disp=FFFFE999; op_data=−999 (11'h419). NEG alone then ENTER → op_data=0.
- **Limits/editing:**
  - Keys 1,2,3,4 → 4th key pulses key_err, disp=FFFFF123.
  - Keys 0,0,5 → FFFFFFF5.
  - Keys 4,5, BKSP → FFFFFFF4.
  - NEG, BKSP ×2 → FFFFFFFF.
  - Codes 0xE, 0xF → key_err, no change.
- **Backpressure:** ENTER with op_ready=0 for 6 cycles while pressing digits → key_err per key, op_valid held 1, op_data stable, disp unchanged; raise op_ready → single handshake, buffer cleared.
- **Reset mid-operation:** reset during PRESENT → next cycle op_valid=0, disp=FFFFFFFF, op_data=0; a subsequent entry of 7 and ENTER yields op_data=7.
